// File: rtl/gate_array_pipe.sv
// Pipelined bitwise two-operand gate unit with a stateful chained-AND mode.
// Results are queued in a DEPTH-entry FIFO behind valid/ready handshakes.
module gate_array_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in_a,
  input  logic [WIDTH-1:0]                 in_b,
  input  logic [2:0]                       in_op,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_y,
  output logic                             out_all,
  output logic                             out_any,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             accept;
  logic             pop;
  logic [WIDTH-1:0] result;

  // No full bypass: a pop in the same cycle does not free a slot for this beat.
  assign in_ready  = !rst && (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_y   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_all = out_valid && (&out_y);
  assign out_any = |out_y;
  assign count   = count_q;

  always_comb begin
    result = '0;
    unique case (in_op)
      3'd0: result = in_a & in_b;
      3'd1: result = in_a | in_b;
      3'd2: result = in_a ^ in_b;
      3'd3: result = ~(in_a & in_b);
      3'd4: result = ~(in_a | in_b);
      3'd5: result = ~(in_a ^ in_b);
      3'd6: result = in_a & ~in_b;
      3'd7: result = acc_q & in_a & in_b;
      default: result = '0;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    acc_d    = acc_q;
    if (accept) begin
      mem_d[wr_ptr_q] = result;
      wr_ptr_d        = wr_ptr_q + AW'(1);
      if (in_op == 3'd7) acc_d = result;
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      acc_q    <= '1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
    end
  end

endmodule
